systolic_operand_feeder: RTL and testbench

//  Upstream stage of the NxN output-stationary systolic array built from the PE tiles.

---
 rtl/systolic_operand_feeder_pkg.sv | 27 ++
 rtl/systolic_operand_feeder_operand_bank.sv | 43 ++++
 rtl/systolic_operand_feeder.sv | 161 ++++++++++++++++
 tb/tb_systolic_operand_feeder.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/systolic_operand_feeder_pkg.sv
// Shared definitions for the systolic operand feeder: FSM encoding and
// phase-length / counter-width helpers derived from the array dimension.
package systolic_operand_feeder_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_CLR,
        ST_FEED,
        ST_DRAIN
    } state_t;

    // FEED_LEN: cycles for the full diagonal skew to pass the array edge
    function automatic int unsigned feed_len(input int unsigned n);
        return 2 * n - 1;
    endfunction

    // DRAIN_LEN: array propagation + multiplier pipeline + accumulate
    function automatic int unsigned drain_len(input int unsigned n, input int unsigned mul_lat);
        return n + mul_lat;
    endfunction

    function automatic int unsigned cnt_w(input int unsigned len);
        return (len < 2) ? 1 : $clog2(len);
    endfunction

endpackage

// File: rtl/systolic_operand_feeder_operand_bank.sv
// N x N operand store: one full-row write port, N skewed read lanes.
// Lane i returns element i of entry (t - i), or 0 outside the skew window.
module operand_bank
    import systolic_operand_feeder_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned N          = 4,
    parameter int unsigned K_W        = 2,
    parameter int unsigned T_W        = 3
) (
    input  logic                    clk,
    input  logic                    wr_en,
    input  logic [K_W-1:0]          wr_idx,
    input  logic [N*DATA_WIDTH-1:0] wr_data,
    input  logic [T_W-1:0]          rd_t,
    output logic [N*DATA_WIDTH-1:0] rd_data
);

    for (genvar i = 0; i < N; i++) begin : g_lane
        logic [DATA_WIDTH-1:0] mem [N];
        logic [T_W-1:0]        idx;
        logic [DATA_WIDTH-1:0] val;

        // Each lane owns its column of storage; no reset on operand data
        always_ff @(posedge clk) begin
            if (wr_en) begin
                mem[wr_idx] <= wr_data[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end

        // Unsigned t - i: the t >= i guard keeps a wrapped index from reading
        always_comb begin
            idx = rd_t - T_W'(i);
            val = '0;
            if ((rd_t >= T_W'(i)) && (idx < T_W'(N))) begin
                val = mem[idx[K_W-1:0]];
            end
        end

        assign rd_data[i*DATA_WIDTH +: DATA_WIDTH] = val;
    end

endmodule

// File: rtl/systolic_operand_feeder.sv
// Buffers one A/B operand set, then drives the systolic array edges with the
// diagonal skew, issues the accumulator clear and flags when C_out is final.
module systolic_operand_feeder
    import systolic_operand_feeder_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned N          = 4,
    parameter int unsigned MUL_LAT    = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    clear,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [N*DATA_WIDTH-1:0] in_a_col,
    input  logic [N*DATA_WIDTH-1:0] in_b_row,
    output logic [N*DATA_WIDTH-1:0] a_out,
    output logic [N*DATA_WIDTH-1:0] b_out,
    output logic                    pe_clr_n,
    output logic                    busy,
    output logic                    done
);

    localparam int unsigned FEED_LEN  = feed_len(N);
    localparam int unsigned DRAIN_LEN = drain_len(N, MUL_LAT);
    localparam int unsigned K_W       = cnt_w(N);
    localparam int unsigned T_W       = cnt_w(FEED_LEN);
    localparam int unsigned D_W       = cnt_w(DRAIN_LEN);
    localparam int unsigned VEC_W     = N * DATA_WIDTH;

    state_t         state;
    logic [K_W-1:0] k_cnt;
    logic [T_W-1:0] t_cnt;
    logic [D_W-1:0] d_cnt;

    logic             wr_en;
    logic [T_W-1:0]   rd_t;
    logic [VEC_W-1:0] a_rd;
    logic [VEC_W-1:0] b_rd;

    assign in_ready = (state == ST_IDLE) || (state == ST_LOAD);
    assign wr_en    = in_valid && in_ready && !clear;

    // Banks are read one step ahead so the registered edge value matches t
    assign rd_t = (state == ST_FEED) ? t_cnt + T_W'(1) : '0;

    operand_bank #(
        .DATA_WIDTH (DATA_WIDTH),
        .N          (N),
        .K_W        (K_W),
        .T_W        (T_W)
    ) u_bank_a (
        .clk     (clk),
        .wr_en   (wr_en),
        .wr_idx  (k_cnt),
        .wr_data (in_a_col),
        .rd_t    (rd_t),
        .rd_data (a_rd)
    );

    operand_bank #(
        .DATA_WIDTH (DATA_WIDTH),
        .N          (N),
        .K_W        (K_W),
        .T_W        (T_W)
    ) u_bank_b (
        .clk     (clk),
        .wr_en   (wr_en),
        .wr_idx  (k_cnt),
        .wr_data (in_b_row),
        .rd_t    (rd_t),
        .rd_data (b_rd)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= ST_IDLE;
            k_cnt    <= '0;
            t_cnt    <= '0;
            d_cnt    <= '0;
            a_out    <= '0;
            b_out    <= '0;
            pe_clr_n <= 1'b1;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else if (clear) begin
            state    <= ST_IDLE;
            k_cnt    <= '0;
            t_cnt    <= '0;
            d_cnt    <= '0;
            a_out    <= '0;
            b_out    <= '0;
            pe_clr_n <= 1'b1;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (in_valid) begin
                        state <= ST_LOAD;
                        k_cnt <= K_W'(1);
                        busy  <= 1'b1;
                    end
                end
                ST_LOAD: begin
                    if (in_valid) begin
                        if (k_cnt == K_W'(N - 1)) begin
                            state    <= ST_CLR;
                            k_cnt    <= '0;
                            pe_clr_n <= 1'b0;
                        end else begin
                            k_cnt <= k_cnt + K_W'(1);
                        end
                    end
                end
                ST_CLR: begin
                    state    <= ST_FEED;
                    t_cnt    <= '0;
                    pe_clr_n <= 1'b1;
                    a_out    <= a_rd;
                    b_out    <= b_rd;
                end
                ST_FEED: begin
                    if (t_cnt == T_W'(FEED_LEN - 1)) begin
                        state <= ST_DRAIN;
                        t_cnt <= '0;
                        d_cnt <= '0;
                        a_out <= '0;
                        b_out <= '0;
                    end else begin
                        t_cnt <= t_cnt + T_W'(1);
                        a_out <= a_rd;
                        b_out <= b_rd;
                    end
                end
                ST_DRAIN: begin
                    if (d_cnt == D_W'(DRAIN_LEN - 1)) begin
                        state <= ST_IDLE;
                        d_cnt <= '0;
                        busy  <= 1'b0;
                    end else begin
                        d_cnt <= d_cnt + D_W'(1);
                        done  <= (d_cnt == D_W'(DRAIN_LEN - 2));
                    end
                end
                default: begin
                    state    <= ST_IDLE;
                    k_cnt    <= '0;
                    t_cnt    <= '0;
                    d_cnt    <= '0;
                    a_out    <= '0;
                    b_out    <= '0;
                    pe_clr_n <= 1'b1;
                    busy     <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_systolic_operand_feeder.sv
// Randomised bench for systolic_operand_feeder: checks edge skew per cycle
// against the matrix definition and C_out of a behavioural PE array against A*B.
module tb_systolic_operand_feeder;

    localparam int DW      = 8;
    localparam int N       = 4;
    localparam int MUL_LAT = 1;
    localparam int VW      = N * DW;
    localparam int FEED_C  = 2 * N - 1;
    localparam int DONE_C  = FEED_C + N + MUL_LAT;
    localparam int JOB_LEN = N + 1 + FEED_C + N + MUL_LAT;

    logic          clk = 1'b0;
    logic          rst;
    logic          clear;
    logic          in_valid;
    logic          in_ready;
    logic [VW-1:0] in_a_col;
    logic [VW-1:0] in_b_row;
    logic [VW-1:0] a_out;
    logic [VW-1:0] b_out;
    logic          pe_clr_n;
    logic          busy;
    logic          done;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    logic [DW-1:0] ma [N][N];
    logic [DW-1:0] mb [N][N];

    systolic_operand_feeder #(
        .DATA_WIDTH (DW),
        .N          (N),
        .MUL_LAT    (MUL_LAT)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .clear    (clear),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_a_col (in_a_col),
        .in_b_row (in_b_row),
        .a_out    (a_out),
        .b_out    (b_out),
        .pe_clr_n (pe_clr_n),
        .busy     (busy),
        .done     (done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural output-stationary array: a flows east, b south, 1-cycle multiplier
    logic [DW-1:0] ah [N][N], bv [N][N], ain [N][N], bin [N][N];
    logic [15:0]   prod [N][N], cacc [N][N];

    always_comb begin
        for (int i = 0; i < N; i++) begin
            ain[i][0] = a_out[i*DW +: DW];
            bin[0][i] = b_out[i*DW +: DW];
            for (int j = 1; j < N; j++) begin
                ain[i][j] = ah[i][j-1];
                bin[j][i] = bv[j-1][i];
            end
        end
    end

    always @(posedge clk) begin
        for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
                if (!rst || !pe_clr_n) begin
                    ah[i][j]   <= '0;
                    bv[i][j]   <= '0;
                    prod[i][j] <= '0;
                    cacc[i][j] <= '0;
                end else begin
                    ah[i][j]   <= ain[i][j];
                    bv[i][j]   <= bin[i][j];
                    prod[i][j] <= 16'(ain[i][j]) * 16'(bin[i][j]);
                    cacc[i][j] <= cacc[i][j] + prod[i][j];
                end
            end
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [VW-1:0] col_a(input int k);
        logic [VW-1:0] v;
        for (int i = 0; i < N; i++) v[i*DW +: DW] = ma[i][k];
        return v;
    endfunction

    function automatic logic [VW-1:0] row_b(input int k);
        logic [VW-1:0] v;
        for (int j = 0; j < N; j++) v[j*DW +: DW] = mb[k][j];
        return v;
    endfunction

    // West edge at skew step t: lane i carries A[i][t-i] inside the window
    function automatic logic [VW-1:0] exp_a(input int t);
        logic [VW-1:0] v = '0;
        for (int i = 0; i < N; i++)
            if (t - i >= 0 && t - i < N) v[i*DW +: DW] = ma[i][t-i];
        return v;
    endfunction

    function automatic logic [VW-1:0] exp_b(input int t);
        logic [VW-1:0] v = '0;
        for (int j = 0; j < N; j++)
            if (t - j >= 0 && t - j < N) v[j*DW +: DW] = mb[t-j][j];
        return v;
    endfunction

    function automatic logic [15:0] exp_c(input int i, input int j);
        logic [15:0] s = '0;
        for (int k = 0; k < N; k++) s = s + 16'(ma[i][k]) * 16'(mb[k][j]);
        return s;
    endfunction

    task automatic set_mats(input int kind);
        for (int r = 0; r < N; r++) begin
            for (int c = 0; c < N; c++) begin
                case (kind)
                    0: begin ma[r][c] = (r == c) ? 8'd1 : 8'd0; mb[r][c] = DW'(4*r + c + 1); end
                    1: begin ma[r][c] = DW'(16*r + c + 1); mb[r][c] = DW'($urandom); end
                    3: begin ma[r][c] = 8'hFF; mb[r][c] = 8'hFF; end
                    default: begin ma[r][c] = DW'($urandom); mb[r][c] = DW'($urandom); end
                endcase
            end
        end
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_busy"}, 64'(busy), 64'd0);
        check({tag, "_ready"}, 64'(in_ready), 64'd1);
        check({tag, "_done"}, 64'(done), 64'd0);
        check({tag, "_a"}, 64'(a_out), 64'd0);
        check({tag, "_b"}, 64'(b_out), 64'd0);
        check({tag, "_clrn"}, 64'(pe_clr_n), 64'd1);
    endtask

    // mode: 0 back-to-back, 1 fixed stall pattern, 2 random stalls
    // abort: 0 none, 1 clear at FEED t=2 with a beat, 2 rst pulse mid-DRAIN
    task automatic run_job(input int mode, input int abort, input bit skew, input bit force_v);
        int  k = 0, pi = 0, n_cyc = 0, t0, first_cyc = 0;
        bit  v;
        bit  pat [7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        while (k < N && n_cyc < 64) begin
            v = (mode == 0) ? 1'b1 : (mode == 1) ? pat[pi % 7] : 1'($urandom_range(0, 1));
            pi++;
            in_valid = v;
            in_a_col = v ? col_a(k) : VW'($urandom);
            in_b_row = v ? row_b(k) : VW'($urandom);
            check("load_ready", 64'(in_ready), 64'd1);
            t0 = cyc;
            @(posedge clk); #1;
            n_cyc++;
            if (v) begin
                if (k == 0) first_cyc = t0;
                k++;
            end
        end
        check("load_beats", 64'(k), 64'(N));
        if (mode == 1) check("pattern_len", 64'(pi), 64'd7);
        for (int c = 0; c <= DONE_C; c++) begin
            check("clrn", 64'(pe_clr_n), (c == 0) ? 64'd0 : 64'd1);
            check("busy_ready", {62'd0, busy, in_ready}, 64'd2);
            check("a_edge", 64'(a_out), (c >= 1 && c <= FEED_C) ? 64'(exp_a(c - 1)) : 64'd0);
            check("b_edge", 64'(b_out), (c >= 1 && c <= FEED_C) ? 64'(exp_b(c - 1)) : 64'd0);
            check("done", 64'(done), (c == DONE_C) ? 64'd1 : 64'd0);
            if (skew && c == 1) check("skew_t0", 64'(a_out), 64'h0000_0001);
            if (skew && c == 4) check("skew_t3", 64'(a_out), 64'h3122_1304);
            if (skew && c == FEED_C) check("skew_t6", 64'(a_out), 64'h3400_0000);
            if (c == DONE_C) begin
                if (mode == 0) check("job_len", 64'(cyc - first_cyc + 1), 64'(JOB_LEN));
                for (int i = 0; i < N; i++)
                    for (int j = 0; j < N; j++)
                        check($sformatf("c_out_%0d%0d", i, j), 64'(cacc[i][j]), 64'(exp_c(i, j)));
            end
            if (abort == 1 && c == 3) begin
                clear    = 1'b1;
                in_valid = 1'b1;
                in_a_col = VW'($urandom);
                in_b_row = VW'($urandom);
                @(posedge clk); #1;
                clear    = 1'b0;
                in_valid = 1'b0;
                check_idle("clear");
                repeat (DONE_C) begin
                    @(posedge clk); #1;
                    check("clear_nodone", {62'd0, done, busy}, 64'd0);
                end
                return;
            end
            if (abort == 2 && c == 10) begin
                in_valid = 1'b0;
                rst = 1'b0;
                #1;
                check_idle("rst_async");
                @(posedge clk); #1;
                rst = 1'b1;
                repeat (6) begin
                    @(posedge clk); #1;
                    check("rst_nodone", {62'd0, done, busy}, 64'd0);
                end
                return;
            end
            in_valid = force_v ? 1'b1 : 1'($urandom_range(0, 1));
            in_a_col = VW'($urandom);
            in_b_row = VW'($urandom);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        check_idle("post_job");
    endtask

    initial begin
        rst      = 1'b0;
        clear    = 1'b0;
        in_valid = 1'b0;
        in_a_col = '0;
        in_b_row = '0;
        repeat (3) @(posedge clk);
        #1;
        check_idle("reset");
        rst = 1'b1;
        @(posedge clk); #1;
        check_idle("idle");

        set_mats(0); run_job(0, 0, 1'b0, 1'b0);
        set_mats(1); run_job(0, 0, 1'b1, 1'b0);
        set_mats(2); run_job(1, 0, 1'b0, 1'b0);
        set_mats(2); run_job(0, 1, 1'b0, 1'b1);
        set_mats(2); run_job(0, 0, 1'b0, 1'b0);
        set_mats(2); run_job(2, 2, 1'b0, 1'b0);
        set_mats(2); run_job(0, 0, 1'b0, 1'b0);
        set_mats(3); run_job(0, 0, 1'b0, 1'b1);
        check("ff_c00", 64'(cacc[0][0]), 64'hF804);
        for (int n = 0; n < 6; n++) begin
            set_mats(2);
            run_job(2, 0, 1'b0, n[0]);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
